// File: rtl/adsr_engine.sv
// Time-multiplexed ADSR envelope engine: each sample_tick starts one sweep that
// updates every voice once, in order, and streams the post-update state and volume.
//   state   | meaning
//   BLANK   | silent, volume held at 0
//   ATTACK  | ramping up by attack_rate toward VMAX
//   DECAY   | ramping down by decay_rate toward SUS
//   SUSTAIN | volume follows sustain_value live
//   RELEASE | ramping down by release_rate toward 0
module adsr_engine #(
   parameter  int NUM_VOICES = 8,
   parameter  int VOL_W      = 18,
   parameter  int RATE_W     = 7,
   localparam int VIDX_W     = $clog2(NUM_VOICES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_tick,
   input  logic [RATE_W-1:0] attack_rate,
   input  logic [RATE_W-1:0] decay_rate,
   input  logic [RATE_W-1:0] release_rate,
   input  logic [RATE_W-1:0] sustain_value,
   input  logic              ev_valid,
   output logic              ev_ready,
   input  logic [VIDX_W-1:0] ev_voice,
   input  logic              ev_on,
   output logic              out_valid,
   output logic [VIDX_W-1:0] out_voice,
   output logic [2:0]        out_state,
   output logic [VOL_W-1:0]  out_volume,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_BLANK   = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   localparam logic [VOL_W-1:0]  VMAX = {1'b0, {(VOL_W-1){1'b1}}};
   localparam logic [VIDX_W-1:0] LAST = VIDX_W'(NUM_VOICES - 1);

   logic [2:0]            state_q [NUM_VOICES];
   logic [VOL_W-1:0]      vol_q   [NUM_VOICES];
   logic [NUM_VOICES-1:0] pp_q, pp_d, pr_q, pr_d;
   logic                  busy_q, ev_ready_q;
   logic [VIDX_W-1:0]     vidx_q;
   logic                  out_valid_q;
   logic [VIDX_W-1:0]     out_voice_q;
   logic [2:0]            out_state_q;
   logic [VOL_W-1:0]      out_vol_q;

   logic [2:0]       cur_st, nxt_st;
   logic [VOL_W-1:0] cur_vol, nxt_vol;
   logic             cur_p, cur_r;
   logic [VOL_W-1:0] sus, ar_ext, dr_ext, rr_ext;
   logic [VOL_W:0]   att_sum;
   logic [VOL_W-1:0] att_next, dec_sat, dec_next, rel_next;

   assign sus    = {{(VOL_W-RATE_W-5){1'b0}}, sustain_value, 5'b0};
   assign ar_ext = {{(VOL_W-RATE_W){1'b0}}, attack_rate};
   assign dr_ext = {{(VOL_W-RATE_W){1'b0}}, decay_rate};
   assign rr_ext = {{(VOL_W-RATE_W){1'b0}}, release_rate};

   assign cur_st  = state_q[vidx_q];
   assign cur_vol = vol_q[vidx_q];
   assign cur_p   = pp_q[vidx_q];
   assign cur_r   = pr_q[vidx_q];

   // All ramps saturate: attack at VMAX, decay at SUS (even from below), release at 0.
   assign att_sum  = {1'b0, cur_vol} + {1'b0, ar_ext};
   assign att_next = (att_sum > {1'b0, VMAX}) ? VMAX : att_sum[VOL_W-1:0];
   assign dec_sat  = (cur_vol >= dr_ext) ? cur_vol - dr_ext : '0;
   assign dec_next = (dec_sat < sus) ? sus : dec_sat;
   assign rel_next = (cur_vol >= rr_ext) ? cur_vol - rr_ext : '0;

   always_comb begin
      nxt_st  = cur_st;
      nxt_vol = cur_vol;
      case (cur_st)
         ST_ATTACK: begin
            if (cur_r) begin
               nxt_st = ST_RELEASE;
            end else begin
               nxt_vol = att_next;
               if (att_next == VMAX) nxt_st = ST_DECAY;
            end
         end
         ST_DECAY: begin
            if (cur_r) begin
               nxt_st = ST_RELEASE;
            end else if (cur_p) begin
               nxt_st = ST_ATTACK;
            end else begin
               nxt_vol = dec_next;
               if (dec_next == sus) nxt_st = ST_SUSTAIN;
            end
         end
         ST_SUSTAIN: begin
            nxt_vol = sus;
            if (cur_p)      nxt_st = ST_ATTACK;
            else if (cur_r) nxt_st = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (cur_p) begin
               nxt_st = ST_ATTACK;
            end else begin
               nxt_vol = rel_next;
               if (rel_next == '0) nxt_st = ST_BLANK;
            end
         end
         default: begin
            nxt_vol = '0;
            nxt_st  = cur_p ? ST_ATTACK : ST_BLANK;
         end
      endcase
   end

   // The event set is applied after the consume-clear so it survives a same-cycle collision.
   always_comb begin
      pp_d = pp_q;
      pr_d = pr_q;
      if (busy_q) begin
         pp_d[vidx_q] = 1'b0;
         pr_d[vidx_q] = 1'b0;
      end
      if (ev_valid && ev_ready_q) begin
         pp_d[ev_voice] = ev_on;
         pr_d[ev_voice] = ~ev_on;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            state_q[i] <= ST_BLANK;
            vol_q[i]   <= '0;
         end
         pp_q        <= '0;
         pr_q        <= '0;
         busy_q      <= 1'b0;
         vidx_q      <= '0;
         ev_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_voice_q <= '0;
         out_state_q <= '0;
         out_vol_q   <= '0;
      end else begin
         ev_ready_q  <= 1'b1;
         pp_q        <= pp_d;
         pr_q        <= pr_d;
         out_valid_q <= busy_q;
         if (busy_q) begin
            state_q[vidx_q] <= nxt_st;
            vol_q[vidx_q]   <= nxt_vol;
            out_voice_q     <= vidx_q;
            out_state_q     <= nxt_st;
            out_vol_q       <= nxt_vol;
            vidx_q          <= vidx_q + VIDX_W'(1);
            if (vidx_q == LAST) busy_q <= 1'b0;
         end else if (sample_tick) begin
            busy_q <= 1'b1;
            vidx_q <= '0;
         end
      end
   end

   assign ev_ready   = ev_ready_q;
   assign busy       = busy_q;
   assign out_valid  = out_valid_q;
   assign out_voice  = out_voice_q;
   assign out_state  = out_state_q;
   assign out_volume = out_vol_q;

endmodule

// File: tb/tb_adsr_engine.sv
// Scoreboard bench for adsr_engine (4 voices): stimulus pushes expected per-voice
// results, a negedge monitor pops and compares each out_valid beat.
module tb_adsr_engine;
   localparam int NV = 4;
   localparam int VW = 18;
   localparam int RW = 7;
   localparam logic [VW-1:0] VMAX = 18'd131071;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sample_tick = 1'b0;
   logic [RW-1:0] attack_rate = '0, decay_rate = '0, release_rate = '0, sustain_value = '0;
   logic          ev_valid = 1'b0, ev_on = 1'b0;
   logic [1:0]    ev_voice = '0;
   logic          ev_ready, out_valid, busy;
   logic [1:0]    out_voice;
   logic [2:0]    out_state;
   logic [VW-1:0] out_volume;

   adsr_engine #(.NUM_VOICES(NV), .VOL_W(VW), .RATE_W(RW)) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick),
      .attack_rate(attack_rate), .decay_rate(decay_rate),
      .release_rate(release_rate), .sustain_value(sustain_value),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_voice(ev_voice), .ev_on(ev_on),
      .out_valid(out_valid), .out_voice(out_voice), .out_state(out_state),
      .out_volume(out_volume), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    voice;
      logic [2:0]    st;
      logic [VW-1:0] vol;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic exp_sweep(input int vx, input logic [2:0] st, input logic [VW-1:0] vol);
      for (int v = 0; v < NV; v++) begin
         if (v == vx) sb_q.push_back({2'(v), st, vol});
         else         sb_q.push_back({2'(v), 3'd0, 18'd0});
      end
   endtask

   task automatic sweep(input int vx, input logic [2:0] st, input logic [VW-1:0] vol);
      exp_sweep(vx, st, vol);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      repeat (5) step();
   endtask

   task automatic send_ev(input int v, input logic on);
      ev_voice = 2'(v);
      ev_on    = on;
      ev_valid = 1'b1;
      step();
      ev_valid = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (out_valid === 1'b1) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: voice %0d state %0d vol %0d, expected no output",
                     out_voice, out_state, out_volume);
         end else begin
            e = sb_q.pop_front();
            if ({out_voice, out_state, out_volume} !== e) begin
               n_fail++;
               $display("FAIL out_beat: got voice %0d state %0d vol %0d, expected voice %0d state %0d vol %0d",
                        out_voice, out_state, out_volume, e.voice, e.st, e.vol);
            end
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      attack_rate   = 7'd127;
      decay_rate    = 7'd0;
      release_rate  = 7'd0;
      sustain_value = 7'd64;

      // Reset with a press and a tick presented: both must be discarded.
      rst = 1'b1; ev_valid = 1'b1; ev_voice = 2'd0; ev_on = 1'b1; sample_tick = 1'b1;
      repeat (3) step();
      check("rst_ev_ready", 32'(ev_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0; ev_valid = 1'b0; sample_tick = 1'b0;
      step();
      check("ev_ready_after_rst", 32'(ev_ready), 32'd1);
      check("busy_idle", 32'(busy), 32'd0);
      sweep(-1, 3'd0, 18'd0);

      // Reset mid-sweep: only voice 0's beat escapes before the abort.
      send_ev(0, 1'b1);
      sweep(0, 3'd1, 18'd0);
      sweep(0, 3'd1, 18'd127);
      sb_q.push_back({2'd0, 3'd1, 18'd254});
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("midsweep_out_valid", 32'(out_valid), 32'd0);
      check("midsweep_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step();
      sweep(-1, 3'd0, 18'd0);

      // Attack clamp on voice 2.
      send_ev(2, 1'b1);
      for (int s = 1; s <= 1034; s++) begin
         if (s == 1)         sweep(2, 3'd1, 18'd0);
         else if (s < 1034)  sweep(2, 3'd1, 18'(127 * (s - 1)));
         else                sweep(2, 3'd2, VMAX);
      end
      sweep(2, 3'd2, VMAX);

      // Decay floor at SUS = 64 << 5 = 2048.
      decay_rate = 7'd100;
      for (int n = 1; n <= 1290; n++) sweep(2, 3'd2, 18'(131071 - 100 * n));
      sweep(2, 3'd3, 18'd2048);
      sweep(2, 3'd3, 18'd2048);

      // Release to silence.
      release_rate = 7'd127;
      send_ev(2, 1'b0);
      sweep(2, 3'd4, 18'd2048);
      for (int k = 2; k <= 17; k++) sweep(2, 3'd4, 18'(2048 - 127 * (k - 1)));
      sweep(2, 3'd0, 18'd0);

      // Collision: press voice 1 in the cycle voice 1 is processed.
      exp_sweep(-1, 3'd0, 18'd0);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      ev_voice = 2'd1; ev_on = 1'b1; ev_valid = 1'b1;
      step();
      ev_valid = 1'b0;
      repeat (3) step();
      sweep(1, 3'd1, 18'd0);

      // Overrun: tick held high for three back-to-back sweeps.
      for (int s = 1; s <= 3; s++) exp_sweep(1, 3'd1, 18'(127 * s));
      sample_tick = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         step();
         check("busy_overrun", 32'(busy), 32'((i % 5) != 0));
      end
      step();
      sample_tick = 1'b0;
      check("busy_overrun_end", 32'(busy), 32'd0);
      repeat (3) step();
      check("no_restart", 32'(busy), 32'd0);
      sweep(1, 3'd1, 18'd508);

      repeat (3) step();
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
